trng_serial_sched: RTL
======================

Name: trng_serial_sched

Overview:
Sequences TRNG output bytes onto the serial link as framed packets under host RTS flow control. Each packet is a sync byte, an 8-bit sequence number, PKT_LEN payload bytes pulled from the TRNG byte stream, and an XOR checksum, sent as UART 8N1. Sits between the TRNG conditioning/FIFO stage and the o_serial_data pin inside trng_top, clocked from the PLL clock.

Parameters:
BAUD_DIV, 833, clock cycles per UART bit (96 MHz / 115200); legal range 2..65535
PKT_LEN, 64, payload bytes per packet; legal range 1..255
SYNC_BYTE, 8'hA5, first byte of every packet

Ports:
i_clk  input  1  PLL clock; all logic on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_dat  input  8  random byte from TRNG stream
i_dat_valid  input  1  i_dat is valid
o_dat_ready  output  1  byte accepted when i_dat_valid & o_dat_ready
i_serial_rts_n  input  1  host RTS, active low = host may receive; asynchronous to i_clk
o_serial_data  output  1  UART TX line, idle high
o_busy  output  1  frame in flight or packet partially sent
o_stall  output  1  next byte due but held off by RTS
o_pkt_cnt  output  16  packets fully transmitted, wraps at 65535

Behaviour:
- Reset (async assert, sync deassert by upstream): o_serial_data=1, o_dat_ready=0, o_busy=0, o_stall=0, o_pkt_cnt=0, seq=0, chk=0, FSM=IDLE, shifter idle.
- i_serial_rts_n passes a 2-FF synchronizer; rts_ok = ~sync output (2-cycle latency). Synchronizer resets to 1 (not ok).
- Packet FSM: IDLE -> SYNC -> SEQ -> PAYLOAD -> CHK -> IDLE.
  - IDLE: leaves for SYNC when i_dat_valid=1, so packets are started only when data exists.
  - SYNC: loads SYNC_BYTE. SEQ: loads seq; chk <= seq.
  - PAYLOAD: o_dat_ready = shifter idle & rts_ok. On handshake, load i_dat, chk <= chk ^ i_dat, byte count++. After the PKT_LEN-th byte, go to CHK. If i_dat_valid=0, wait indefinitely (no timeout; no padding).
  - CHK: loads chk. Once its frame completes: o_pkt_cnt++, seq++ (8-bit wrap), then IDLE.
- Byte-load rule (all states): a byte loads only in a cycle where the shifter is idle and rts_ok=1. o_stall=1 in any non-IDLE cycle where the shifter is idle and rts_ok=0. RTS is sampled only at byte boundaries; a frame in flight always completes.
- Shifter frame:
  - Start bit (0) begins the cycle after load, then 8 data bits LSB first, then 1 stop bit (1); each bit lasts exactly BAUD_DIV cycles.
  - Shifter is idle from the cycle after the last stop cycle.
  - Back-to-back frames: next start bit is exactly 10*BAUD_DIV+1 cycles after the previous start bit.
- o_busy = (FSM != IDLE) | shifter active.
- Reset mid-frame: line returns to 1 immediately; the partial packet is abandoned; seq restarts at 0.
- Baud counter is 16 bits. Byte counter is 8 bits and compares against PKT_LEN; no wrap inside a packet.

Decomposition:
- Package trng_ser_pkg holds:
  - packet FSM state enum (IDLE, SYNC, SEQ, PAYLOAD, CHK)
  - shifter state enum (IDLE, START, DATA, STOP)
  - FRAME_BITS=10
  - default SYNC_BYTE
- Sub-module trng_uart_tx: baud counter + shift register. Ports: i_clk, i_reset_n, i_load, i_byte[7:0], o_idle, o_txd. Parameter: BAUD_DIV.
- The packet FSM, checksum, RTS synchronizer and counters stay in trng_serial_sched.

Test Plan:
- BAUD_DIV=4, PKT_LEN=4, RTS low, bytes 01,02,03,04 offered continuously.
  - Line decodes A5,00,01,02,03,04,04 (checksum = 00^01^02^03^04).
  - Each frame is 40 cycles; start bits are 41 cycles apart.
  - o_pkt_cnt=1 after the CHK stop bit.
- Two consecutive packets: second packet has seq=01. Checksum uses seq^payload; payload 10,20,30,40 with seq 01 -> checksum 01^10^20^30^40 = 41.
- Deassert RTS (high) during the 2nd payload frame.
  - That frame completes.
  - o_stall=1 and the line stays 1 while RTS is high.
  - After RTS goes low, the next start bit appears 3 cycles later (2 sync cycles + load).
- i_dat_valid drops after 2 payload bytes for 100 cycles.
  - o_dat_ready=1 and the line idles high throughout.
  - Packet resumes with the 3rd byte; no padding is inserted.
- Assert i_reset_n=0 mid-data-bit of the SEQ frame.
  - o_serial_data=1 in the same cycle; o_busy=0.
  - After release, the next packet starts with A5,00.
- Run 256 packets with PKT_LEN=1: seq wraps FF->00 and o_pkt_cnt=256.

Source files
------------

// File: rtl/trng_ser_pkg.sv
// trng_ser_pkg: shared state encodings and framing constants for the TRNG serial scheduler
package trng_ser_pkg;

    typedef enum logic [2:0] {
        PKT_IDLE,
        PKT_SYNC,
        PKT_SEQ,
        PKT_PAYLOAD,
        PKT_CHK
    } pkt_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/trng_uart_tx.sv
// trng_uart_tx: 8N1 UART transmitter, one byte per i_load pulse while idle
module trng_uart_tx
    import trng_ser_pkg::*;
#(
    parameter int BAUD_DIV = 833
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_idle,
    output logic       o_txd
);

    tx_state_t   r_state, w_state_nxt;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_txd;
    logic        w_tick;
    logic        w_txd_nxt;

    assign w_tick = r_baud == 16'(BAUD_DIV - 1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_IDLE:  w_state_nxt = i_load ? TX_START : TX_IDLE;
            TX_START: w_state_nxt = w_tick ? TX_DATA : TX_START;
            TX_DATA:  w_state_nxt = (w_tick && r_bit == 3'd7) ? TX_STOP : TX_DATA;
            TX_STOP:  w_state_nxt = w_tick ? TX_IDLE : TX_STOP;
            default:  w_state_nxt = TX_IDLE;
        endcase
    end

    // txd is registered from the next state so the pin never glitches on state changes
    always_comb begin
        w_txd_nxt = 1'b1;
        if (w_state_nxt == TX_START)
            w_txd_nxt = 1'b0;
        else if (w_state_nxt == TX_DATA)
            w_txd_nxt = (r_state == TX_DATA && w_tick) ? r_shift[1] : r_shift[0];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_txd   <= w_txd_nxt;
            if (r_state == TX_IDLE) begin
                r_baud <= '0;
                r_bit  <= '0;
                if (i_load)
                    r_shift <= i_byte;
            end else begin
                r_baud <= w_tick ? '0 : r_baud + 16'd1;
                if (w_tick && r_state == TX_DATA) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 3'd1;
                end
            end
        end
    end

    assign o_idle = r_state == TX_IDLE;
    assign o_txd  = r_txd;

endmodule

// File: rtl/trng_serial_sched.sv
// trng_serial_sched: frames TRNG bytes as sync/seq/payload/checksum packets on a UART under RTS
module trng_serial_sched
    import trng_ser_pkg::*;
#(
    parameter int         BAUD_DIV  = 833,
    parameter int         PKT_LEN   = 64,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_dat,
    input  logic        i_dat_valid,
    output logic        o_dat_ready,
    input  logic        i_serial_rts_n,
    output logic        o_serial_data,
    output logic        o_busy,
    output logic        o_stall,
    output logic [15:0] o_pkt_cnt
);

    pkt_state_t  r_state, w_state_nxt;
    logic        r_rts_s1, r_rts_s2;
    logic [7:0]  r_seq;
    logic [7:0]  r_chk;
    logic [7:0]  r_cnt;
    logic        r_chk_sent;
    logic [15:0] r_pkt_cnt;
    logic        w_idle;
    logic        w_can;
    logic        w_hs;
    logic        w_last;
    logic        w_done;
    logic        w_load;
    logic [7:0]  w_byte;

    // a byte may only be loaded at a byte boundary while the host accepts data
    assign w_can  = w_idle & ~r_rts_s2;
    assign w_hs   = (r_state == PKT_PAYLOAD) & w_can & i_dat_valid;
    assign w_last = r_cnt == 8'(PKT_LEN - 1);
    assign w_done = (r_state == PKT_CHK) & r_chk_sent & w_idle;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_byte      = SYNC_BYTE;
        case (r_state)
            PKT_IDLE:    w_state_nxt = i_dat_valid ? PKT_SYNC : PKT_IDLE;
            PKT_SYNC: begin
                w_load      = w_can;
                w_state_nxt = w_can ? PKT_SEQ : PKT_SYNC;
            end
            PKT_SEQ: begin
                w_load      = w_can;
                w_byte      = r_seq;
                w_state_nxt = w_can ? PKT_PAYLOAD : PKT_SEQ;
            end
            PKT_PAYLOAD: begin
                w_load      = w_hs;
                w_byte      = i_dat;
                w_state_nxt = (w_hs && w_last) ? PKT_CHK : PKT_PAYLOAD;
            end
            PKT_CHK: begin
                w_load      = w_can & ~r_chk_sent;
                w_byte      = r_chk;
                w_state_nxt = w_done ? PKT_IDLE : PKT_CHK;
            end
            default:     w_state_nxt = PKT_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= PKT_IDLE;
            r_rts_s1   <= 1'b1;
            r_rts_s2   <= 1'b1;
            r_seq      <= '0;
            r_chk      <= '0;
            r_cnt      <= '0;
            r_chk_sent <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rts_s1 <= i_serial_rts_n;
            r_rts_s2 <= r_rts_s1;
            if (r_state == PKT_SEQ && w_can)
                r_chk <= r_seq;
            if (w_hs) begin
                r_chk <= r_chk ^ i_dat;
                r_cnt <= w_last ? '0 : r_cnt + 8'd1;
            end
            if (r_state == PKT_CHK && w_load)
                r_chk_sent <= 1'b1;
            if (w_done) begin
                r_chk_sent <= 1'b0;
                r_pkt_cnt  <= r_pkt_cnt + 16'd1;
                r_seq      <= r_seq + 8'd1;
            end
        end
    end

    trng_uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tx (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_load   (w_load),
        .i_byte   (w_byte),
        .o_idle   (w_idle),
        .o_txd    (o_serial_data)
    );

    assign o_dat_ready = (r_state == PKT_PAYLOAD) & w_can;
    assign o_busy      = (r_state != PKT_IDLE) | ~w_idle;
    assign o_stall     = (r_state != PKT_IDLE) & w_idle & r_rts_s2;
    assign o_pkt_cnt   = r_pkt_cnt;

endmodule
